fir_tap_seq: RTL
================

FIR_TAP_SEQ -- requirements
Module: fir_tap_seq

Interface
REQ-001 SHALL have parameter DW, default 32, data/coefficient width.
REQ-002 SHALL have parameter AW, default 4, tap/data RAM address width.
REQ-003 SHALL have parameter NTAP_MAX, default 11, maximum tap count (<= 2^AW).
REQ-004 axis_clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ap_start  in  1  one-cycle start pulse; ignored unless idle.
REQ-007 ap_idle / ap_done  out  1  idle level; done one-cycle pulse.
REQ-008 tap_num  in  AW  active taps, 1..NTAP_MAX, sampled at ap_start.
REQ-009 data_length  in  32  samples per run, >= 1, sampled at ap_start.
REQ-010 ss_tvalid, ss_tdata[DW], ss_tlast  in; ss_tready  out  AXI-Stream sample input.
REQ-011 sm_tvalid, sm_tdata[DW], sm_tlast  out; sm_tready  in  AXI-Stream result output.
REQ-012 tap_addr  out  AW; tap_rdata  in  DW  coefficient RAM, read data valid 1 cycle after address.
REQ-013 dat_we  out  1; dat_addr  out  AW; dat_wdata  out  DW; dat_rdata  in  DW  sample RAM, 1-cycle read.
REQ-014 mac_clr, mac_en  out  1; mac_a, mac_b  out  DW; mac_result  in  DW  external MAC (clr resets accumulator synchronously).

Function
REQ-015 States SHALL be IDLE, CLEAR, WAIT_IN, WRITE, MAC, DRAIN, OUT.
REQ-016 IDLE: ap_idle=1; ap_start -> CLEAR, head=0, sample count=0.
REQ-017 CLEAR: dat_we=1, dat_wdata=0, dat_addr 0..tap_num-1 over tap_num cycles -> WAIT_IN.
REQ-018 WAIT_IN: ss_tready=1 only in this state; handshake registers ss_tdata -> WRITE.
REQ-019 WRITE (1 cycle): dat_we=1 at dat_addr=head; mac_clr=1 -> MAC with tap index i=0.
REQ-020 MAC: for i=0..tap_num-1, one per cycle, tap_addr=i, dat_addr=(head-i) mod tap_num; after last index -> DRAIN.
REQ-021 mac_en SHALL assert exactly one cycle after each MAC-state address, with mac_a=tap_rdata, mac_b=dat_rdata; tap_num pulses per sample.
REQ-022 DRAIN: 1 cycle (last accumulate lands) -> OUT; sm_tdata=mac_result registered.
REQ-023 Latency: sm_tvalid SHALL rise tap_num+3 cycles after ss handshake cycle.
REQ-024 OUT: sm_tvalid=1, sm_tdata/sm_tlast stable until sm_tready; on handshake head=(head+1) mod tap_num, count+1; count==data_length -> IDLE with ap_done pulse, else WAIT_IN.
REQ-025 Wrap: head SHALL wrap tap_num-1 -> 0; tap_num=1 uses single slot.
REQ-026 Arithmetic modulo 2^DW, no saturation (MAC-owned).
REQ-027 ap_start outside IDLE SHALL be ignored.

Reset
REQ-028 reset SHALL force IDLE; ap_idle=1; ap_done, ss_tready, sm_tvalid, sm_tlast, dat_we, mac_en=0; mac_clr=1 during reset; head, count=0.
REQ-029 Reset mid-MAC or mid-OUT SHALL abort; pending result discarded.

Configuration
REQ-030 FIR_LAST_COUNT_EN defined: sm_tlast=1 on sample data_length, ss_tlast ignored.
REQ-031 Undefined: sm_tlast SHALL equal ss_tlast captured with that sample; run still ends on data_length.

Structure
REQ-032 Shared package fir_pkg SHALL hold state enum, DW/AW/NTAP_MAX defaults.
REQ-033 Sub-module fir_ring_addr SHALL compute (head-i) mod tap_num and head increment.

Verification
REQ-034 tap_num=3, taps{1,2,3}, data_length=4, inputs 1,2,3,4 -> outputs 1,4,10,16; last output sm_tlast=1; ap_done once.
REQ-035 sm_tready low 5 cycles on 2nd output -> sm_tdata held 4, ss_tready=0 throughout.
REQ-036 Latency: tap_num=3 -> sm_tvalid exactly 6 cycles after handshake; mac_en 3 pulses.
REQ-037 tap_num=11, 12 samples of 1, taps all 1 -> outputs 1..11 then 11 (wrap).
REQ-038 reset asserted during MAC of 2nd sample, then new ap_start with inputs 5 -> output 5 (history cleared).
REQ-039 tap_num=1, tap 7, inputs 2,3 -> outputs 14,21.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer: FSM state encoding and
// default parameter values used by the interface, the address helper and the top.
package fir_pkg;

   localparam int unsigned DW_DEF       = 32;
   localparam int unsigned AW_DEF       = 4;
   localparam int unsigned NTAP_MAX_DEF = 11;
   localparam int unsigned LEN_W        = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT_IN,
      S_WRITE,
      S_MAC,
      S_DRAIN,
      S_OUT
   } fir_state_e;

endpackage

// File: rtl/fir_tap_seq_if.sv
// AXI-Stream bundle (valid/ready/data/last) used for both the sample input
// and the result output of the FIR tap sequencer.
//   master : drives tvalid, tdata, tlast; receives tready
//   slave  : receives tvalid, tdata, tlast; drives tready
interface fir_tap_seq_if
   import fir_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) ();

   logic          tvalid;
   logic          tready;
   logic [DW-1:0] tdata;
   logic          tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/fir_ring_addr.sv
// Circular-buffer address helper for the sample RAM.
//   i_head     : slot holding the newest sample
//   i_idx      : tap index (0 = newest sample)
//   i_ntap     : active tap count (ring size)
//   o_addr     : (i_head - i_idx) mod i_ntap
//   o_head_nxt : (i_head + 1) mod i_ntap
// Both head and idx are always below i_ntap, so one conditional add/sub suffices.
module fir_ring_addr #(
   parameter int unsigned AW = 4
) (
   input  logic [AW-1:0] i_head,
   input  logic [AW-1:0] i_idx,
   input  logic [AW-1:0] i_ntap,
   output logic [AW-1:0] o_addr,
   output logic [AW-1:0] o_head_nxt
);

   assign o_addr     = (i_head >= i_idx) ? (i_head - i_idx) : (i_head + i_ntap - i_idx);
   assign o_head_nxt = (i_head == (i_ntap - AW'(1))) ? '0 : (i_head + AW'(1));

endmodule

// File: rtl/fir_tap_seq.sv
// FIR tap sequencer: accepts one sample per AXI-Stream beat, stores it in a
// circular sample RAM, walks tap_num coefficient/sample pairs through an
// external MAC and returns the accumulated result on the output stream.
// Ports:
//   axis_clk, reset            : clock, synchronous active-high reset
//   ap_start/ap_idle/ap_done   : run control (start pulse, idle level, done pulse)
//   tap_num, data_length       : run configuration, sampled at ap_start
//   ss (slave), sm (master)    : sample input / result output streams
//   tap_addr, tap_rdata        : coefficient RAM (1-cycle read)
//   dat_we/addr/wdata/rdata    : sample RAM (1-cycle read)
//   mac_clr/en/a/b, mac_result : external multiply-accumulate unit
// Build option: define FIR_LAST_COUNT_EN to generate sm_tlast from the sample
// count (last of data_length); otherwise sm_tlast follows the captured ss_tlast.
module fir_tap_seq
   import fir_pkg::*;
#(
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned NTAP_MAX = NTAP_MAX_DEF
) (
   input  logic             axis_clk,
   input  logic             reset,
   input  logic             ap_start,
   output logic             ap_idle,
   output logic             ap_done,
   input  logic [AW-1:0]    tap_num,
   input  logic [LEN_W-1:0] data_length,
   fir_tap_seq_if.slave     ss,
   fir_tap_seq_if.master    sm,
   output logic [AW-1:0]    tap_addr,
   input  logic [DW-1:0]    tap_rdata,
   output logic             dat_we,
   output logic [AW-1:0]    dat_addr,
   output logic [DW-1:0]    dat_wdata,
   input  logic [DW-1:0]    dat_rdata,
   output logic             mac_clr,
   output logic             mac_en,
   output logic [DW-1:0]    mac_a,
   output logic [DW-1:0]    mac_b,
   input  logic [DW-1:0]    mac_result
);

   fir_state_e       r_state;
   logic [AW-1:0]    r_ntap;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_count;
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_idx;
   logic             r_last;
   logic             r_ap_idle;
   logic             r_ap_done;
   logic             r_ss_tready;
   logic             r_sm_tvalid;
   logic             r_sm_tlast;
   logic [AW-1:0]    r_tap_addr;
   logic             r_dat_we;
   logic [AW-1:0]    r_dat_addr;
   logic [DW-1:0]    r_dat_wdata;
   logic             r_mac_clr;
   logic             r_mac_en;

   logic [AW-1:0]    w_ntap_in;
   logic [AW-1:0]    w_idx_nxt;
   logic [AW-1:0]    w_ring_addr;
   logic [AW-1:0]    w_head_nxt;
   logic [LEN_W-1:0] w_count_nxt;

   // Keep an out-of-range tap count inside 1..NTAP_MAX.
   always_comb begin
      w_ntap_in = tap_num;
      if (tap_num == '0) begin
         w_ntap_in = AW'(1);
      end else if (LEN_W'(tap_num) > LEN_W'(NTAP_MAX)) begin
         w_ntap_in = AW'(NTAP_MAX);
      end
   end

   assign w_idx_nxt   = r_idx + AW'(1);
   assign w_count_nxt = r_count + LEN_W'(1);

   fir_ring_addr #(.AW(AW)) u_ring (
      .i_head     (r_head),
      .i_idx      (w_idx_nxt),
      .i_ntap     (r_ntap),
      .o_addr     (w_ring_addr),
      .o_head_nxt (w_head_nxt)
   );

   // Sequencer FSM with all control outputs registered alongside the state.
   always_ff @(posedge axis_clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ntap      <= AW'(1);
         r_len       <= '0;
         r_count     <= '0;
         r_head      <= '0;
         r_idx       <= '0;
         r_last      <= 1'b0;
         r_ap_idle   <= 1'b1;
         r_ap_done   <= 1'b0;
         r_ss_tready <= 1'b0;
         r_sm_tvalid <= 1'b0;
         r_sm_tlast  <= 1'b0;
         r_tap_addr  <= '0;
         r_dat_we    <= 1'b0;
         r_dat_addr  <= '0;
         r_dat_wdata <= '0;
         r_mac_clr   <= 1'b1;
         r_mac_en    <= 1'b0;
      end else begin
         r_ap_done <= 1'b0;
         r_mac_clr <= 1'b0;
         // Each MAC-state address produces one accumulate a cycle later.
         r_mac_en  <= (r_state == S_MAC);
         case (r_state)
            S_IDLE: begin
               if (ap_start) begin
                  r_ntap      <= w_ntap_in;
                  r_len       <= data_length;
                  r_head      <= '0;
                  r_count     <= '0;
                  r_idx       <= '0;
                  r_ap_idle   <= 1'b0;
                  r_dat_we    <= 1'b1;
                  r_dat_addr  <= '0;
                  r_dat_wdata <= '0;
                  r_state     <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (r_idx == (r_ntap - AW'(1))) begin
                  r_dat_we    <= 1'b0;
                  r_ss_tready <= 1'b1;
                  r_state     <= S_WAIT_IN;
               end else begin
                  r_idx      <= w_idx_nxt;
                  r_dat_addr <= w_idx_nxt;
               end
            end
            S_WAIT_IN: begin
               if (ss.tvalid && r_ss_tready) begin
                  r_ss_tready <= 1'b0;
                  r_dat_we    <= 1'b1;
                  r_dat_addr  <= r_head;
                  r_dat_wdata <= ss.tdata;
                  r_last      <= ss.tlast;
                  r_mac_clr   <= 1'b1;
                  r_state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_dat_we   <= 1'b0;
               r_idx      <= '0;
               r_tap_addr <= '0;
               r_dat_addr <= r_head;
               r_state    <= S_MAC;
            end
            S_MAC: begin
               if (r_idx == (r_ntap - AW'(1))) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_idx      <= w_idx_nxt;
                  r_tap_addr <= w_idx_nxt;
                  r_dat_addr <= w_ring_addr;
               end
            end
            S_DRAIN: begin
               r_sm_tvalid <= 1'b1;
`ifdef FIR_LAST_COUNT_EN
               r_sm_tlast  <= (w_count_nxt == r_len);
`else
               r_sm_tlast  <= r_last;
`endif
               r_state     <= S_OUT;
            end
            S_OUT: begin
               if (sm.tready) begin
                  r_sm_tvalid <= 1'b0;
                  r_sm_tlast  <= 1'b0;
                  r_head      <= w_head_nxt;
                  r_count     <= w_count_nxt;
                  if (w_count_nxt == r_len) begin
                     r_ap_done <= 1'b1;
                     r_ap_idle <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     r_ss_tready <= 1'b1;
                     r_state     <= S_WAIT_IN;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ap_idle   = r_ap_idle;
   assign ap_done   = r_ap_done;
   assign ss.tready = r_ss_tready;
   assign sm.tvalid = r_sm_tvalid;
   assign sm.tlast  = r_sm_tlast;
   // The MAC accumulator is itself a register and is neither cleared nor
   // enabled while in OUT, so it is presented directly as the held result.
   assign sm.tdata  = mac_result;
   assign tap_addr  = r_tap_addr;
   assign dat_we    = r_dat_we;
   assign dat_addr  = r_dat_addr;
   assign dat_wdata = r_dat_wdata;
   assign mac_clr   = r_mac_clr;
   assign mac_en    = r_mac_en;
   // RAM read data is aligned with mac_en by construction.
   assign mac_a     = tap_rdata;
   assign mac_b     = dat_rdata;

endmodule
